// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types for the load/store unit: access size encoding,
//                controller states and the alignment/size legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // True when the size is reserved or the byte offset does not match the
    // natural alignment of the access.
    function automatic logic size_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo;
            SZ_RSV:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_if
//  Description : Core request/response channel plus word-addressed data
//                memory port of the load/store unit.
//  Modports    : master - the LSU (accepts requests, drives memory port)
//                slave  - the environment (core datapath + data memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
);
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    size_e             req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [IDX_W-1:0]  mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational little-endian lane steering. Extracts and
//                extends the addressed byte/half of a memory word for loads,
//                and builds the read-modify-write word for sub-word stores.
//  Ports       : word      in  32  memory word read at the access index
//                addr_lo   in  2   byte offset within the word
//                size      in  2   access size
//                is_signed in  1   sign-extend loads
//                wdata     in  16  sub-word store data (low bits)
//                load_data out 32  extended load result
//                merged    out 32  word with the addressed lane replaced
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = {addr_lo, 3'b000};
    assign w_half_sh = {addr_lo[1], 4'b0000};
    assign w_byte    = word[w_byte_sh +: 8];
    assign w_half    = word[w_half_sh +: 16];

    always_comb begin
        load_data = 32'd0;
        merged    = word;
        case (size)
            SZ_B: begin
                load_data                = {{24{is_signed & w_byte[7]}}, w_byte};
                merged[w_byte_sh +: 8]   = wdata[7:0];
            end
            SZ_H: begin
                load_data                = {{16{is_signed & w_half[15]}}, w_half};
                merged[w_half_sh +: 16]  = wdata;
            end
            SZ_W: begin
                load_data = word;
            end
            default: begin
                load_data = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit controller. Accepts one byte/half/word load
//                or store, checks it, and drives a word-addressed memory with
//                async read / sync full-word write. Sub-word stores are done
//                as read-modify-write.
//  Ports       : clk   in  1  rising-edge clock
//                rst_n in  1  asynchronous active-low reset
//                bus   lsu_if.master  request/response + memory port
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 32
)(
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.master  bus
);

    localparam int               IDX_W       = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-3:0] C_MEM_WORDS = (ADDR_W-2)'(MEM_WORDS);

    state_e           r_state;
    logic             r_we;
    size_e            r_size;
    logic             r_signed;
    logic [1:0]       r_addr_lo;
    logic [15:0]      r_wdata;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [31:0]      r_resp_rdata;
    logic [IDX_W-1:0] r_mem_addr;
    logic             r_mem_we;
    logic [31:0]      r_mem_wdata;

    logic             w_accept;
    logic             w_req_err;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged;

    assign w_accept  = bus.req_valid && r_req_ready;
    assign w_req_err = size_misaligned(bus.req_size, bus.req_addr[1:0])
                    || (bus.req_addr[ADDR_W-1:2] >= C_MEM_WORDS);

    lsu_lane_align u_align (
        .word      (bus.mem_rdata),
        .addr_lo   (r_addr_lo),
        .size      (r_size),
        .is_signed (r_signed),
        .wdata     (r_wdata),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_signed     <= 1'b0;
            r_addr_lo    <= 2'd0;
            r_wdata      <= 16'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata[15:0];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            // Rejected requests never touch the memory port.
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_mem_addr <= bus.req_addr[2 +: IDX_W];
                            r_state    <= ACCESS;
                            // Full-word stores need no read, so the write
                            // enable is set up to be live during ACCESS.
                            if (bus.req_we && (bus.req_size == SZ_W)) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= bus.req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_size == SZ_W) begin
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_mem_wdata  <= w_merged;
                        r_mem_we     <= 1'b1;
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl with a behavioural 64-word
//                memory and an expected-response queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 64;
    localparam int IDX_W     = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32), .IDX_W(IDX_W)) bus ();

    lsu_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural memory: async read, sync write; preload port for setup.
    logic [31:0]      mem [MEM_WORDS];
    logic             pl_we   = 1'b0;
    logic [IDX_W-1:0] pl_idx  = '0;
    logic [31:0]      pl_data = 32'd0;
    int               we_cnt  = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt            <= we_cnt + 1;
        end else if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [15:0] we_mask;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic        o_to;
    logic        o_err;
    logic [31:0] o_rd;
    int          o_lat;
    logic [15:0] o_wm;

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_idx  = idx[IDX_W-1:0];
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Drive one request (accepted at the following posedge) and queue its
    // expected response.
    task automatic drive_req(input logic we, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic e_err, input logic [31:0] e_rd,
                             input int e_lat, input logic [15:0] e_we);
        sb.push_back('{err: e_err, rdata: e_rd, lat: e_lat, we_mask: e_we});
        @(negedge clk);
        bus.req_we     = we;
        bus.req_size   = size_e'(sz);
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid; latency counts cycles after the accept
    // edge, we_mask marks the cycles in which mem_we was high.
    task automatic collect_resp(output logic to, output logic err, output logic [31:0] rd,
                                output int lat, output logic [15:0] wm);
        to = 1'b1; err = 1'b0; rd = 32'd0; lat = 0; wm = 16'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) wm[k] = 1'b1;
            if (bus.resp_valid === 1'b1) begin
                to  = 1'b0;
                lat = k;
                err = bus.resp_err;
                rd  = bus.resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        rst_n = 1'b0;
        preload(3, 32'h8899AABB);
        preload(5, 32'h11223344);
        preload(8, 32'h00000000);
        preload(9, 32'h01234567);
        preload(63, 32'hCAFEF00D);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd0)
            $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        else n_pass++;
        n_checks++;
        if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0)
            $display("FAIL reset_mem: mem_addr=%0d mem_we=%b, expected 0 0", bus.mem_addr, bus.mem_we);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        drive_req(1'b0, 2'd0, 1'b1, 32'h0E, 32'd0, 1'b0, 32'hFFFFFF99, 2, 16'h0000);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL load_byte_s: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL resp_pulse: valid=%b ready=%b, expected 0 1", bus.resp_valid, bus.req_ready);
        else n_pass++;

        drive_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'd0, 1'b0, 32'h00008899, 2, 16'h0000);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL load_half_u: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;

        drive_req(1'b0, 2'd1, 1'b1, 32'h0C, 32'd0, 1'b0, 32'hFFFFAABB, 2, 16'h0000);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL load_half_s: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;

        drive_req(1'b0, 2'd0, 1'b0, 32'h0F, 32'd0, 1'b0, 32'h00000088, 2, 16'h0000);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL load_byte_u: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;

        // Last valid word index.
        drive_req(1'b0, 2'd2, 1'b0, 32'hFC, 32'd0, 1'b0, 32'hCAFEF00D, 2, 16'h0000);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL load_word_top: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;
    endtask

    task automatic test_store_byte();
        int w0;
        w0 = we_cnt;
        drive_req(1'b1, 2'd0, 1'b0, 32'h15, 32'h000000EE, 1'b0, 32'd0, 3, 16'h0004);
        collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
        e = sb.pop_front(); n_checks++;
        if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
            $display("FAIL store_byte: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                     o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem[5] !== 32'h1122EE44 || (we_cnt - w0) !== 1)
            $display("FAIL store_byte_mem: mem5=%h writes=%0d, expected 1122ee44 1", mem[5], we_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_errors();
        int w0;
        logic [1:0]  sz_t [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad_t [4] = '{32'h06, 32'h03, 32'h00, 32'h100};
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hFFFFFFFF, 1'b1, 32'd0, 1, 16'h0000);
            collect_resp(o_to, o_err, o_rd, o_lat, o_wm);
            e = sb.pop_front(); n_checks++;
            if (o_to || o_err !== e.err || o_rd !== e.rdata || o_lat !== e.lat || o_wm !== e.we_mask)
                $display("FAIL error_%0d: to=%b err=%b rdata=%h lat=%0d we=%h, expected err=%b rdata=%h lat=%0d we=%h",
                         i, o_to, o_err, o_rd, o_lat, o_wm, e.err, e.rdata, e.lat, e.we_mask);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ((we_cnt - w0) !== 0 || mem[0] === 32'hFFFFFFFF)
            $display("FAIL error_no_write: writes=%0d, expected 0", we_cnt - w0);
        else n_pass++;
    endtask

    // Word store immediately followed by a word load with req_valid held high.
    task automatic test_back_to_back();
        logic [7:0]  rdy_mask;
        logic [15:0] wm;
        int          n_resp;
        rdy_mask = 8'd0; wm = 16'd0; n_resp = 0;
        sb.push_back('{err: 1'b0, rdata: 32'd0,        lat: 2, we_mask: 16'h0});
        sb.push_back('{err: 1'b0, rdata: 32'hDEADBEEF, lat: 5, we_mask: 16'h0});
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = SZ_W; bus.req_signed = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0; bus.req_wdata = 32'h0BADF00D;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rdy_mask[k] = bus.req_ready;
            if (bus.mem_we === 1'b1) wm[k] = 1'b1;
            if (bus.resp_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front(); n_resp++; n_checks++;
                if (bus.resp_err !== e.err || bus.resp_rdata !== e.rdata || k !== e.lat)
                    $display("FAIL b2b_resp%0d: err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                             n_resp, bus.resp_err, bus.resp_rdata, k, e.err, e.rdata, e.lat);
                else n_pass++;
            end
            if (k == 5) bus.req_valid = 1'b0;
        end
        n_checks++;
        if (n_resp !== 2 || rdy_mask !== 8'b0000_1000 || wm !== 16'h0002)
            $display("FAIL b2b_handshake: resps=%0d ready=%b we=%h, expected 2 00001000 0002", n_resp, rdy_mask, wm);
        else n_pass++;
        n_checks++;
        if (mem[8] !== 32'hDEADBEEF)
            $display("FAIL b2b_mem: mem8=%h, expected deadbeef", mem[8]);
        else n_pass++;
        sb.delete();
        @(negedge clk);
    endtask

    // Reset asserted while the RMW write is pending.
    task automatic test_reset_in_write();
        int w0;
        w0 = we_cnt;
        drive_req(1'b1, 2'd1, 1'b0, 32'h26, 32'h0000BEEF, 1'b0, 32'd0, 3, 16'h0004);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b1)
            $display("FAIL rst_write_phase: mem_we=%b, expected 1", bus.mem_we);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0)
            $display("FAIL rst_we_drop: mem_we=%b, expected 0", bus.mem_we);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
                $display("FAIL rst_release_%0d: ready=%b valid=%b, expected 1 0", k, bus.req_ready, bus.resp_valid);
            else n_pass++;
        end
        n_checks++;
        if (mem[9] !== 32'h01234567 || (we_cnt - w0) !== 0)
            $display("FAIL rst_mem: mem9=%h writes=%0d, expected 01234567 0", mem[9], we_cnt - w0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_errors();
        test_back_to_back();
        test_reset_in_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
